// File: rtl/pipe_out_fifo.sv
// Output FIFO behind a pipeline stage: first-word fall-through storage with
// a saturating sum of accepted samples and drop statistics for overruns.
// DEPTH must be a power of two between 2 and 16 so pointers wrap naturally.
module pipe_out_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               sum,
  output logic [3:0]               drop_cnt,
  output logic                     ovf,
  input  logic                     clr_stats
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough that sum + sample never overflows before the saturation test.
  localparam int SW = ((W > 8) ? W : 8) + 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SUM_MAX  = SW'(255);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  logic [SW-1:0] sum_wide;
  logic [7:0]    sum_sat;

  // Handshake decode; in_ready deliberately ignores out_ready so a full FIFO
  // drops even when it pops in the same cycle.
  always_comb begin
    in_ready  = (count < CNT_FULL);
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    drop      = in_valid && !in_ready;
    out_data  = mem[rd_ptr];
    sum_wide  = SW'(sum) + SW'(in_data);
    sum_sat   = (sum_wide > SUM_MAX) ? 8'hFF : sum_wide[7:0];
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Statistics; a clear wins over any same-cycle accumulate or drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr_stats) begin
      sum      <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) sum <= sum_sat;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 4'hF) drop_cnt <= drop_cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/pipe_out_fifo.md
PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

Interface
REQ-001 Parameter W, default 4, width of each data sample.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; the block SHALL support only powers of two, 2 to 16.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  the upstream pipeline result on in_data is valid this cycle.
REQ-006 in_data  input  W  upstream pipeline result sample.
REQ-007 in_ready  output  1  the FIFO can accept a sample this cycle.
REQ-008 out_valid  output  1  out_data holds the oldest stored sample.
REQ-009 out_data  output  W  head-of-FIFO sample.
REQ-010 out_ready  input  1  the consumer takes the head sample this cycle.
REQ-011 count  output  clog2(DEPTH)+1  number of stored entries, 0 to DEPTH.
REQ-012 sum  output  8  saturating sum of all accepted samples.
REQ-013 drop_cnt  output  4  saturating count of dropped samples.
REQ-014 ovf  output  1  sticky flag: at least one sample was dropped.
REQ-015 clr_stats  input  1  synchronous clear of sum, drop_cnt and ovf.

Function
REQ-016 The block SHALL assert in_ready exactly when count < DEPTH; the block SHALL NOT qualify in_ready with same-cycle out_ready.
REQ-017 A push SHALL occur when in_valid && in_ready: the block writes in_data at wr_ptr and advances wr_ptr modulo DEPTH.
REQ-018 A pop SHALL occur when out_valid && out_ready: the block advances rd_ptr modulo DEPTH.
REQ-019 The block SHALL assert out_valid exactly when count != 0.
REQ-020 out_data SHALL equal mem[rd_ptr] (first-word fall-through); out_data is don't-care while out_valid=0.
REQ-021 Latency: a sample pushed at edge N SHALL appear on out_data after edge N when the FIFO was empty; the block SHALL provide no same-cycle bypass.
REQ-022 Count update: push only gives count+1; pop only gives count-1; push and pop in the same cycle leave count unchanged and both pointers advance.
REQ-023 Full boundary: when count=DEPTH and out_ready=1, the block SHALL pop and SHALL drop any in_valid sample in that cycle.
REQ-024 Empty boundary: when count=0 and out_ready=1, no pop SHALL occur and rd_ptr SHALL NOT move.
REQ-025 Drop: when in_valid && !in_ready, the block SHALL increment drop_cnt (saturating at 15), set ovf, and leave FIFO contents untouched.
REQ-026 On each push, sum SHALL become min(sum + zero-extended in_data, 255).
REQ-027 When clr_stats=1, the block SHALL load sum=0, drop_cnt=0 and ovf=0 at the next edge.
REQ-028 clr_stats SHALL take priority over a same-cycle accumulate or drop.
REQ-029 clr_stats SHALL NOT affect FIFO contents, pointers or count.
REQ-030 Pointer wrap: after DEPTH pushes and DEPTH pops, wr_ptr and rd_ptr SHALL both return to 0, and data order SHALL be preserved across the wrap.

Reset
REQ-031 On rst=1, the block SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, sum=0, drop_cnt=0 and ovf=0.
REQ-032 The resulting outputs SHALL be in_ready=1 and out_valid=0.
REQ-033 Memory contents SHALL NOT require reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored samples.
REQ-035 The first push after rst deasserts SHALL write entry 0.

Verification
REQ-036 Basic order: after reset, push 3, 6, 9 on consecutive cycles with out_ready=0 -> count=3, out_valid=1, out_data=3, sum=18.
REQ-037 Drain: from the REQ-036 state, out_ready=1 for 3 cycles -> out_data reads 3, 6, 9 in order, then out_valid=0 and count=0.
REQ-038 Full and drop: 6 consecutive pushes of 15 with out_ready=0, DEPTH=4 -> count=4, in_ready=0, drop_cnt=2, ovf=1, sum=60.
REQ-039 Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> count=3, drop_cnt+1, head advances.
REQ-040 Saturation and clear: 20 pushes of 15 with streaming pops -> sum=255; then clr_stats=1 -> sum=0, ovf=0, count unchanged.
REQ-041 Async reset mid-stream: rst pulsed between edges with count=2 -> count=0 and out_valid=0 immediately, without waiting for a clk edge.
